// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: sequences an external up/down counter through sawtooth or triangle sweeps
// Ports: clk/rst_n clock and async active-low reset; cfg_* sweep bounds, mode and pass count
// (latched by cfg_we in IDLE); start/stop run control; cnt_q counter value in; cnt_en, cnt_load,
// cnt_up, cnt_data counter controls out; busy, done, err, pass_cnt status.
module updown_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [WIDTH-1:0]  cfg_lo,
  input  logic [WIDTH-1:0]  cfg_hi,
  input  logic              cfg_mode,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              start,
  input  logic              stop,
  input  logic [WIDTH-1:0]  cnt_q,
  output logic              cnt_en,
  output logic              cnt_load,
  output logic              cnt_up,
  output logic [WIDTH-1:0]  cnt_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PASS_W-1:0] pass_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN_UP, RUN_DN, DONE} state_t;
  state_t            r_state;
  logic [WIDTH-1:0]  r_lo, r_hi;
  logic              r_mode, r_err;
  logic [PASS_W-1:0] r_passes, r_pass_cnt;
  logic              w_at_hi, w_at_lo, w_eop;
  logic [PASS_W-1:0] w_pc_nx;
  state_t            w_end_state;
  assign w_at_hi = cnt_q == r_hi;
  assign w_at_lo = cnt_q == r_lo;
  // a pass ends at hi in sawtooth, or back at lo in triangle
  assign w_eop = (r_state == RUN_UP && w_at_hi && !r_mode) || (r_state == RUN_DN && w_at_lo);
  assign w_pc_nx = r_pass_cnt + PASS_W'(1);
  // passes_reg of zero means run until stopped
  assign w_end_state = (r_passes != '0 && w_pc_nx == r_passes) ? DONE : (r_mode ? RUN_UP : LOAD);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lo       <= '0;
      r_hi       <= '0;
      r_mode     <= 1'b0;
      r_passes   <= '0;
      r_pass_cnt <= '0;
      r_err      <= 1'b0;
    end else if (r_state == IDLE) begin
      if (cfg_we) begin
        r_lo     <= cfg_lo;
        r_hi     <= cfg_hi;
        r_mode   <= cfg_mode;
        r_passes <= cfg_passes;
        r_err    <= 1'b0;
      end
      if (start && !stop) begin
        if (r_lo > r_hi) r_err <= 1'b1;
        else begin
          r_err      <= 1'b0;
          r_pass_cnt <= '0;
          r_state    <= LOAD;
        end
      end
    end else if (stop) r_state <= IDLE;
    else if (w_eop) begin
      r_pass_cnt <= w_pc_nx;
      r_state    <= w_end_state;
    end else if (r_state == LOAD) r_state <= RUN_UP;
    else if (r_state == RUN_UP && w_at_hi) r_state <= RUN_DN;
    else if (r_state == DONE) r_state <= IDLE;
  end
  // enable and load are Mealy so the counter freezes on the endpoint and on stop in the same cycle
  assign cnt_en   = !stop && ((r_state == RUN_UP && !w_at_hi) || (r_state == RUN_DN && !w_at_lo));
  assign cnt_load = !stop && r_state == LOAD;
  assign cnt_up   = r_state == LOAD || r_state == RUN_UP;
  assign cnt_data = r_lo;
  assign busy     = r_state != IDLE;
  assign done     = r_state == DONE;
  assign err      = r_err;
  assign pass_cnt = r_pass_cnt;
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: directed self-checking bench for updown_sweep_ctrl with a behavioural counter
module tb_updown_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0, cfg_mode = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0] cfg_lo = '0, cfg_hi = '0, cfg_passes = '0;
  logic [3:0] cnt_q, cnt_data, pass_cnt;
  logic       cnt_en, cnt_load, cnt_up, busy, done, err;
  int         errs = 0, checks = 0, dcount = 0;
  int         saw_q [11] = '{0, 3, 4, 5, 6, 6, 3, 4, 5, 6, 6};
  int         tri_q [8]  = '{6, 2, 3, 4, 4, 3, 2, 2};
  updown_sweep_ctrl #(.WIDTH(4), .PASS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .cfg_mode(cfg_mode), .cfg_passes(cfg_passes), .start(start), .stop(stop), .cnt_q(cnt_q),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_data(cnt_data),
    .busy(busy), .done(done), .err(err), .pass_cnt(pass_cnt)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_data;
    else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cfg(input logic [3:0] lo, input logic [3:0] hi, input logic m, input logic [3:0] p);
    cfg_lo = lo; cfg_hi = hi; cfg_mode = m; cfg_passes = p; cfg_we = 1'b1;
    step;
    cfg_we = 1'b0;
  endtask
  task automatic go;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask
  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_en", cnt_en, 0);
    chk("rst_load", cnt_load, 0);
    chk("rst_up", cnt_up, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step;
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);
    chk("idle_pc", pass_cnt, 0);
    chk("idle_data", cnt_data, 0);
    cfg(4'd3, 4'd6, 1'b0, 4'd2);
    chk("saw_data", cnt_data, 3);
    go;
    chk("saw_up_load", cnt_up, 1);
    for (int c = 1; c <= 11; c++) begin
      chk("saw_q", cnt_q, saw_q[c-1]);
      chk("saw_load", cnt_load, c == 1 || c == 6);
      chk("saw_en", cnt_en, (c >= 2 && c <= 4) || (c >= 7 && c <= 9));
      chk("saw_done", done, c == 11);
      chk("saw_pc", pass_cnt, c < 6 ? 0 : (c < 11 ? 1 : 2));
      chk("saw_busy", busy, 1);
      if (c == 3) begin
        cfg_we = 1'b1; cfg_lo = 4'd0; cfg_hi = 4'd15; start = 1'b1;
      end
      if (c == 4) begin
        cfg_we = 1'b0; start = 1'b0;
      end
      step;
    end
    chk("saw_end_busy", busy, 0);
    chk("saw_end_done", done, 0);
    chk("saw_end_pc", pass_cnt, 2);
    chk("saw_cfg_kept", cnt_data, 3);
    cfg(4'd2, 4'd4, 1'b1, 4'd1);
    go;
    for (int c = 1; c <= 8; c++) begin
      chk("tri_q", cnt_q, tri_q[c-1]);
      chk("tri_up", cnt_up, c <= 4);
      chk("tri_en", cnt_en, c == 2 || c == 3 || c == 5 || c == 6);
      chk("tri_done", done, c == 8);
      chk("tri_pc", pass_cnt, c == 8 ? 1 : 0);
      step;
    end
    chk("tri_end_busy", busy, 0);
    cfg(4'd9, 4'd5, 1'b0, 4'd1);
    go;
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    chk("ill_load", cnt_load, 0);
    step;
    chk("ill_err_sticky", err, 1);
    chk("ill_busy2", busy, 0);
    cfg(4'd0, 4'd15, 1'b0, 4'd0);
    chk("ill_err_clr", err, 0);
    go;
    for (int c = 1; c <= 74; c++) begin
      if (c > 1) step;
      if (done) dcount++;
      if (c % 17 == 1) begin
        chk("free_load", cnt_load, 1);
        chk("free_pc", pass_cnt, (c - 1) / 17);
      end else chk("free_q", cnt_q, (c - 2) % 17);
    end
    chk("free_en", cnt_en, 1);
    stop = 1'b1;
    #1;
    chk("stop_en", cnt_en, 0);
    chk("stop_load", cnt_load, 0);
    chk("stop_busy", busy, 1);
    step;
    stop = 1'b0;
    chk("stop_idle", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_pc", pass_cnt, 4);
    chk("stop_q", cnt_q, 4);
    chk("free_no_done", dcount, 0);
    start = 1'b1; stop = 1'b1;
    step;
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_pc", pass_cnt, 4);
    step;
    chk("ss_busy2", busy, 0);
    cfg(4'd5, 4'd5, 1'b0, 4'd0);
    go;
    chk("eq_load", cnt_load, 1);
    repeat (4) step;
    chk("eq_pc", pass_cnt, 2);
    chk("eq_load2", cnt_load, 1);
    step;
    chk("eq_up", cnt_up, 1);
    chk("eq_en", cnt_en, 0);
    chk("eq_q", cnt_q, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_pc", pass_cnt, 0);
    chk("mrst_up", cnt_up, 0);
    chk("mrst_en", cnt_en, 0);
    chk("mrst_load", cnt_load, 0);
    chk("mrst_err", err, 0);
    chk("mrst_data", cnt_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step;
    chk("post_busy", busy, 0);
    chk("post_data", cnt_data, 0);
    chk("post_pc", pass_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer for the team's 4-bit up/down counter with parallel load: it drives that counter's enable, load, direction and load-data inputs and watches its output.
- Produces programmed sawtooth or triangle sweeps between a low and a high bound for a programmed number of passes.
- Sits between the io_in decode logic and the counter instance in a user module.

Parameters:
WIDTH, 4, counter and bound width
PASS_W, 4, width of pass-count config and status

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  config write strobe, accepted only in IDLE
cfg_lo  input  WIDTH  sweep low bound
cfg_hi  input  WIDTH  sweep high bound
cfg_mode  input  1  0 = sawtooth, 1 = triangle
cfg_passes  input  PASS_W  passes to run; 0 = run until stop
start  input  1  begin sweep, accepted only in IDLE
stop  input  1  abort, any state
cnt_q  input  WIDTH  counter output
cnt_en  output  1  counter enable
cnt_load  output  1  counter parallel load
cnt_up  output  1  counter direction, 1 = up
cnt_data  output  WIDTH  counter load data, always equals lo_reg
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at normal completion
err  output  1  sticky: start was rejected because lo > hi
pass_cnt  output  PASS_W  completed passes in the current run

Behaviour:
- Counter contract: at each edge, if load then q <= data; else if en then q <= q ± 1, wrapping mod 2^WIDTH.
- Reset, asynchronous: state IDLE; lo_reg, hi_reg, mode_reg, passes_reg, pass_cnt all 0; err 0; all outputs 0.
- Config: cfg_we in IDLE latches all cfg_* fields at the edge and clears err. cfg_we outside IDLE is ignored.
- FSM states: IDLE, LOAD, RUN_UP, RUN_DN, DONE.
- IDLE, start=1, stop=0:
  - lo_reg > hi_reg: set err, stay IDLE.
  - otherwise: clear err, clear pass_cnt, go to LOAD.
- IDLE, start=1 and stop=1: stop wins; nothing happens.
- LOAD: cnt_load=1, cnt_up=1, cnt_en=0. Next state RUN_UP.
- RUN_UP:
  - cnt_up=1, cnt_en = (cnt_q != hi_reg). This is combinational (Mealy).
  - When cnt_q == hi_reg: triangle goes to RUN_DN; sawtooth ends the pass.
- RUN_DN:
  - cnt_up=0, cnt_en = (cnt_q != lo_reg).
  - When cnt_q == lo_reg: end of pass.
- End of pass, same edge as the transition:
  - pass_cnt increments, wrapping.
  - If passes_reg != 0 and the incremented value == passes_reg: go to DONE.
  - Otherwise sawtooth goes to LOAD and triangle goes to RUN_UP.
- DONE: done=1 for exactly one cycle, cnt_en=0, cnt_load=0. Next state IDLE. pass_cnt holds its value until the next accepted start.
- stop=1 in any non-IDLE state:
  - cnt_en and cnt_load forced to 0 combinationally that cycle.
  - Next state IDLE; done not pulsed; pass_cnt holds.
- Start while busy is ignored.
- Endpoint dwell: in sawtooth, hi is held 1 cycle, then LOAD. In triangle, each turnaround value is held 2 cycles.
- lo == hi is legal. Sawtooth: LOAD plus one RUN_UP cycle per pass. Triangle: adds one RUN_DN cycle.
- cnt_up is 0 in IDLE, RUN_DN and DONE.
- cnt_q is never modified by this block. A cnt_q value outside [lo, hi] in RUN_UP counts up and wraps until it equals hi.

Test Plan:
- Reset mid-run: assert rst_n=0 in RUN_UP -> outputs, busy, pass_cnt and err go to 0 immediately; config regs read 0 after release.
- Sawtooth lo=3, hi=6, passes=2, start -> cnt_q sequence 3,4,5,6,3,4,5,6 (5 cycles per pass); done pulses once 11 cycles after start; pass_cnt=2; busy falls with done.
- Triangle lo=2, hi=4, passes=1 -> cnt_q 2,3,4,4,3,2; cnt_up falls on the second 4; done pulses the cycle after cnt_q returns to 2.
- Illegal bounds lo=9, hi=5, start -> err=1, busy stays 0, no cnt_load; a following cfg_we clears err.
- passes=0, sawtooth lo=0, hi=15 -> runs 4 passes with pass_cnt 1,2,3,4; stop mid-sweep -> cnt_en=0 in the same cycle, IDLE next edge, no done, pass_cnt holds 4.
- cfg_we and start while busy -> ignored (bounds unchanged, sweep uninterrupted); start and stop together in IDLE -> stays IDLE.
